// File: rtl/secure_frv_rng_pkg.sv
// Shared types and constants for the masking randomness source.
// Holds the FSM state set, LFSR taps and the zero-seed substitute.
package secure_frv_rng_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD0,
        ST_LOAD1,
        ST_LOAD2,
        ST_WARMUP,
        ST_RUN
    } rng_state_e;

    // x^32 + x^22 + x^2 + x + 1, Galois form shifting toward the LSB
    localparam logic [31:0] LFSR_TAPS     = 32'h8020_0003;
    localparam logic [31:0] ZERO_SEED_SUB = 32'h0000_0001;

    // An all-zero LFSR would lock up, so a zero seed is replaced.
    function automatic logic [31:0] seed_fix(input logic [31:0] s);
        return (s == 32'h0) ? ZERO_SEED_SUB : s;
    endfunction

endpackage

// File: rtl/secure_frv_lfsr32_step.sv
// One unrolled step of a 32-bit Galois LFSR.
// Applies BIT_WIDTH single-bit shifts combinationally.
module secure_frv_lfsr32_step
    import secure_frv_rng_pkg::*;
#(
    parameter int BIT_WIDTH = 2
) (
    input  logic [31:0] state_in,
    output logic [31:0] state_out
);

    always_comb begin
        state_out = state_in;
        for (int i = 0; i < BIT_WIDTH; i++) begin
            state_out = {1'b0, state_out[31:1]}
                      ^ (state_out[0] ? LFSR_TAPS : 32'h0);
        end
    end

endmodule

// File: rtl/secure_frv_mask_rng.sv
// Randomness source for a DOM masked AND: three seeded LFSRs
// feeding z0/z1/z2, with warm-up and a per-seed take budget.
module secure_frv_mask_rng
    import secure_frv_rng_pkg::*;
#(
    parameter int BIT_WIDTH    = 2,
    parameter int WARMUP_STEPS = 64,
    parameter int RESEED_LIMIT = 65535
) (
    input  logic                 g_clk,
    input  logic                 g_resetn,
    input  logic                 clk_en,
    input  logic                 seed_valid,
    output logic                 seed_ready,
    input  logic [31:0]          seed_data,
    output logic                 rnd_valid,
    input  logic                 rnd_take,
    output logic [BIT_WIDTH-1:0] z0,
    output logic [BIT_WIDTH-1:0] z1,
    output logic [BIT_WIDTH-1:0] z2,
    output logic                 reseed_req
);

    localparam logic [7:0]  WARM_MAX  = 8'(WARMUP_STEPS);
    localparam logic [15:0] TAKE_LAST = 16'(RESEED_LIMIT - 1);

    rng_state_e  state;
    logic [31:0] l0, l1, l2;
    logic [31:0] n0, n1, n2;
    logic [7:0]  warm_cnt;
    logic [15:0] take_cnt;

    secure_frv_lfsr32_step #(.BIT_WIDTH(BIT_WIDTH)) u_step0 (
        .state_in  (l0),
        .state_out (n0)
    );

    secure_frv_lfsr32_step #(.BIT_WIDTH(BIT_WIDTH)) u_step1 (
        .state_in  (l1),
        .state_out (n1)
    );

    secure_frv_lfsr32_step #(.BIT_WIDTH(BIT_WIDTH)) u_step2 (
        .state_in  (l2),
        .state_out (n2)
    );

    always_ff @(posedge g_clk) begin
        if (!g_resetn) begin
            state    <= ST_IDLE;
            l0       <= ZERO_SEED_SUB;
            l1       <= ZERO_SEED_SUB;
            l2       <= ZERO_SEED_SUB;
            warm_cnt <= 8'd0;
            take_cnt <= 16'd0;
        end else if (clk_en) begin
            unique case (state)
                ST_IDLE, ST_LOAD0: begin
                    if (seed_valid) begin
                        l0    <= seed_fix(seed_data);
                        state <= ST_LOAD1;
                    end
                end
                ST_LOAD1: begin
                    if (seed_valid) begin
                        l1    <= seed_fix(seed_data);
                        state <= ST_LOAD2;
                    end
                end
                ST_LOAD2: begin
                    if (seed_valid) begin
                        l2       <= seed_fix(seed_data);
                        warm_cnt <= 8'd0;
                        state    <= ST_WARMUP;
                    end
                end
                ST_WARMUP: begin
                    if (warm_cnt == WARM_MAX) begin
                        take_cnt <= 16'd0;
                        state    <= ST_RUN;
                    end else begin
                        l0       <= n0;
                        l1       <= n1;
                        l2       <= n2;
                        warm_cnt <= warm_cnt + 8'd1;
                    end
                end
                ST_RUN: begin
                    // A reseed overrides a same-cycle take: L0 is replaced,
                    // so stepping L1/L2 alone would waste fresh bits.
                    if (seed_valid) begin
                        l0       <= seed_fix(seed_data);
                        take_cnt <= 16'd0;
                        state    <= ST_LOAD1;
                    end else if (rnd_take) begin
                        l0 <= n0;
                        l1 <= n1;
                        l2 <= n2;
                        if (take_cnt == TAKE_LAST) begin
                            take_cnt <= 16'd0;
                            state    <= ST_IDLE;
                        end else begin
                            take_cnt <= take_cnt + 16'd1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign seed_ready = (state != ST_WARMUP);
    assign reseed_req = (state == ST_IDLE) || (state == ST_LOAD0);
    assign rnd_valid  = (state == ST_RUN);

    assign z0 = l0[BIT_WIDTH-1:0];
    assign z1 = l1[BIT_WIDTH-1:0];
    assign z2 = l2[BIT_WIDTH-1:0];

endmodule

// File: tb/tb_secure_frv_mask_rng.sv
// Bench for secure_frv_mask_rng: two instances (long and short take
// budget) share stimulus and are compared against a seed/step model.
module tb_secure_frv_mask_rng;

    localparam int             BW    = 2;
    localparam int             WARM  = 4;
    localparam logic [31:0]    TAPS  = 32'h8020_0003;

    logic        g_clk;
    logic        rst_n;
    logic        en;
    logic        sv;
    logic        take;
    logic [31:0] sd;

    logic          ra, va, qa;
    logic          rb, vb, qb;
    logic [BW-1:0] za0, za1, za2;
    logic [BW-1:0] zb0, zb1, zb2;

    int n_checks = 0;
    int n_fail   = 0;

    int          lim   [2] = '{1000, 3};
    int          nseed [2];
    int          warm  [2];
    int          left  [2];
    bit          run   [2];
    logic [31:0] lf    [2][3];

    secure_frv_mask_rng #(
        .BIT_WIDTH(BW), .WARMUP_STEPS(WARM), .RESEED_LIMIT(1000)
    ) dut_a (
        .g_clk(g_clk), .g_resetn(rst_n), .clk_en(en),
        .seed_valid(sv), .seed_ready(ra), .seed_data(sd),
        .rnd_valid(va), .rnd_take(take),
        .z0(za0), .z1(za1), .z2(za2), .reseed_req(qa)
    );

    secure_frv_mask_rng #(
        .BIT_WIDTH(BW), .WARMUP_STEPS(WARM), .RESEED_LIMIT(3)
    ) dut_b (
        .g_clk(g_clk), .g_resetn(rst_n), .clk_en(en),
        .seed_valid(sv), .seed_ready(rb), .seed_data(sd),
        .rnd_valid(vb), .rnd_take(take),
        .z0(zb0), .z1(zb1), .z2(zb2), .reseed_req(qb)
    );

    initial begin
        g_clk = 1'b0;
        forever #5 g_clk = ~g_clk;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] adv(input logic [31:0] x);
        logic [31:0] y;
        y = x;
        for (int b = 0; b < BW; b++) begin
            y = (y >> 1) ^ ((y & 32'h1) * TAPS);
        end
        return y;
    endfunction

    function automatic logic [31:0] fix(input logic [31:0] s);
        return (s == 32'h0) ? 32'h1 : s;
    endfunction

    task automatic step_all(input int m);
        for (int k = 0; k < 3; k++) lf[m][k] = adv(lf[m][k]);
    endtask

    task automatic model_edge();
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                nseed[m] = 0;
                warm[m]  = -1;
                run[m]   = 0;
                left[m]  = 0;
                for (int k = 0; k < 3; k++) lf[m][k] = 32'h1;
            end else if (en) begin
                if (warm[m] >= 0) begin
                    if (warm[m] == 0) begin
                        run[m]  = 1;
                        left[m] = lim[m];
                        warm[m] = -1;
                    end else begin
                        step_all(m);
                        warm[m]--;
                    end
                end else if (run[m]) begin
                    if (sv) begin
                        lf[m][0] = fix(sd);
                        nseed[m] = 1;
                        run[m]   = 0;
                    end else if (take) begin
                        step_all(m);
                        left[m]--;
                        if (left[m] == 0) begin
                            run[m]   = 0;
                            nseed[m] = 0;
                        end
                    end
                end else if (sv) begin
                    lf[m][nseed[m]] = fix(sd);
                    nseed[m]++;
                    if (nseed[m] == 3) begin
                        nseed[m] = 0;
                        warm[m]  = WARM;
                    end
                end
            end
        end
    endtask

    task automatic cmp_inst(input int m, input logic v, input logic r,
                            input logic q, input logic [BW-1:0] a,
                            input logic [BW-1:0] b, input logic [BW-1:0] c);
        logic [31:0] e0, e1, e2;
        e0 = lf[m][0];
        e1 = lf[m][1];
        e2 = lf[m][2];
        check($sformatf("i%0d_rnd_valid", m), 32'(v), 32'(run[m]));
        check($sformatf("i%0d_seed_ready", m), 32'(r), 32'(warm[m] < 0));
        check($sformatf("i%0d_reseed_req", m), 32'(q),
              32'(!run[m] && warm[m] < 0 && nseed[m] == 0));
        check($sformatf("i%0d_z0", m), 32'(a), 32'(e0[BW-1:0]));
        check($sformatf("i%0d_z1", m), 32'(b), 32'(e1[BW-1:0]));
        check($sformatf("i%0d_z2", m), 32'(c), 32'(e2[BW-1:0]));
    endtask

    task automatic tick();
        cmp_inst(0, va, ra, qa, za0, za1, za2);
        cmp_inst(1, vb, rb, qb, zb0, zb1, zb2);
        @(posedge g_clk);
        model_edge();
        @(negedge g_clk);
    endtask

    task automatic seed_word(input logic [31:0] w);
        sv = 1'b1;
        sd = w;
        tick();
        sv = 1'b0;
    endtask

    initial begin
        int n;
        int nv;
        rst_n = 1'b0;
        en    = 1'b1;
        sv    = 1'b0;
        take  = 1'b0;
        sd    = 32'h0;
        @(posedge g_clk);
        model_edge();
        @(negedge g_clk);
        tick();
        rst_n = 1'b1;

        // idle with takes: nothing may move
        take = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check("idle_z0", 32'(za0), 32'h1);
        check("idle_valid", 32'(va), 32'h0);
        take = 1'b0;

        seed_word(32'h1234_5678);
        seed_word(32'h0);
        seed_word(32'h9ABC_DEF0);
        n = 0;
        while (!va && n < 40) begin
            tick();
            n++;
        end
        check("warm_latency", n, 5);

        for (int i = 0; i < 20; i++) begin
            take = (i % 2 == 0);
            tick();
        end

        sv   = 1'b1;
        take = 1'b1;
        sd   = $urandom;
        tick();
        sv   = 1'b0;
        take = 1'b0;
        check("reseed_drops_valid", 32'(va), 32'h0);
        seed_word($urandom);
        seed_word($urandom);

        tick();
        tick();
        en = 1'b0;
        sv = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        en = 1'b1;
        sv = 1'b0;
        n  = 10;
        while (!va && n < 60) begin
            tick();
            n++;
        end
        check("stall_latency", n, 13);

        take = 1'b1;
        nv   = 0;
        for (int i = 0; i < 8; i++) begin
            if (vb) nv++;
            tick();
        end
        check("limit_valid_cycles", nv, 3);
        check("limit_reseed_req", 32'(qb), 32'h1);

        for (int i = 0; i < 400; i++) begin
            rst_n = ($urandom_range(0, 63) != 0);
            en    = ($urandom_range(0, 7) != 0);
            sv    = ($urandom_range(0, 5) == 0);
            take  = 1'($urandom_range(0, 1));
            sd    = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
